parity_rx: RTL and testbench

PARITY_RX -- requirements
Module: parity_rx

---
 rtl/parity_rx_if.sv | 23 ++
 rtl/parity_rx.sv | 117 +++++++++++
 tb/tb_parity_rx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/parity_rx_if.sv
// Serial receive bus for parity_rx: the bit-sample strobe and serial line go
// into the receiver, and the decoded frame result and busy flag come out.
interface parity_rx_if;
  logic       en;       // bit-sample enable
  logic       din;      // serial line, idle high
  logic [7:0] data;     // last received byte
  logic       valid;    // one-cycle frame-complete pulse
  logic       par_err;  // parity mismatch, qualified by valid
  logic       frm_err;  // stop bit low, qualified by valid
  logic       busy;     // frame in progress

  // Line side: drives the serial line and strobe, observes the results.
  modport master (
    output en, din,
    input  data, valid, par_err, frm_err, busy
  );

  // Receiver side.
  modport slave (
    input  en, din,
    output data, valid, par_err, frm_err, busy
  );
endinterface

// File: rtl/parity_rx.sv
// Serial frame receiver: start bit 0, 8 data bits LSB first, one parity bit,
// one stop bit. One bit is taken on each clock edge where en is high. At the
// end of each frame the byte and the parity/framing checks are registered and
// flagged with a single-cycle valid pulse.
module parity_rx #(
  parameter bit ODD = 1'b0  // 0: even parity expected, 1: odd parity expected
) (
  input  logic        clk,
  input  logic        rst,
  parity_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_par_bit;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_par_err;
  logic       r_frm_err;
  logic       w_start;
  logic       w_stop_edge;
  logic       w_busy;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values and the blocks can be read in any order.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode; nothing moves on edges where en is low.
  always_comb begin
    // NOTE: the default assignment covers every path through the case, so no
    // latch is inferred for w_next_state.
    w_next_state = r_state;
    if (bus.en) begin
      unique case (r_state)
        IDLE:    if (!bus.din) w_next_state = DATA;
        DATA:    if (r_cnt == 3'd7) w_next_state = PARITY;
        PARITY:  w_next_state = STOP;
        STOP:    w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Per-state outputs: busy flag, start-bit detect and stop-bit sample strobe.
  always_comb begin
    w_busy      = 1'b1;
    w_start     = 1'b0;
    w_stop_edge = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busy  = 1'b0;
        w_start = bus.en & ~bus.din;
      end
      STOP:    w_stop_edge = bus.en;
      default: ;
    endcase
  end

  // Bit counter, data shift register and received parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is ordinary flops, not a RAM, so it takes a
      // defined reset value like the rest of the state.
      r_cnt     <= 3'd0;
      r_shift   <= 8'h00;
      r_par_bit <= 1'b0;
    end else if (w_start) begin
      r_cnt <= 3'd0;
    end else if (bus.en && (r_state == DATA)) begin
      r_shift[r_cnt] <= bus.din;
      r_cnt          <= r_cnt + 3'd1;
    end else if (bus.en && (r_state == PARITY)) begin
      r_par_bit <= bus.din;
    end
  end

  // Frame result: registered on the stop-bit edge; error flags are zero
  // whenever valid is low, while data holds until the next frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_valid <= w_stop_edge;
      if (w_stop_edge) begin
        r_data    <= r_shift;
        r_par_err <= ((^r_shift) ^ r_par_bit) != ODD;
        r_frm_err <= ~bus.din;
      end else begin
        r_par_err <= 1'b0;
        r_frm_err <= 1'b0;
      end
    end
  end

  assign bus.data    = r_data;
  assign bus.valid   = r_valid;
  assign bus.par_err = r_par_err;
  assign bus.frm_err = r_frm_err;
  assign bus.busy    = w_busy;

endmodule

// File: tb/tb_parity_rx.sv
// Testbench for parity_rx: an even-parity and an odd-parity receiver share one
// serial line. A bit-stream model collects en-qualified samples into frames and
// predicts every output on every cycle; directed frames add fixed expectations.
module tb_parity_rx;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic din;

  parity_rx_if bus_even ();
  parity_rx_if bus_odd ();

  assign bus_even.en  = en;
  assign bus_even.din = din;
  assign bus_odd.en   = en;
  assign bus_odd.din  = din;

  parity_rx #(.ODD(1'b0)) u_dut_even (.clk(clk), .rst(rst), .bus(bus_even));
  parity_rx #(.ODD(1'b1)) u_dut_odd  (.clk(clk), .rst(rst), .bus(bus_odd));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the expected outputs.
  bit         m_active;
  bit         m_bits[$];
  logic [7:0] exp_data;
  bit         exp_valid;
  bit         exp_busy;
  bit         exp_pe_even;
  bit         exp_pe_odd;
  bit         exp_fe;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame-level reference: after a 0 sample in idle, gather the next ten
  // enabled samples (8 data, parity, stop) and judge the frame from them.
  task automatic model_step(input bit e, input bit d, input bit r);
    int         ones;
    logic [7:0] byte_v;
    exp_valid   = 1'b0;
    exp_pe_even = 1'b0;
    exp_pe_odd  = 1'b0;
    exp_fe      = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_bits.delete();
      exp_data = 8'h00;
    end else if (e) begin
      if (!m_active) begin
        if (!d) begin
          m_active = 1'b1;
          m_bits.delete();
        end
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == 10) begin
          byte_v = 8'h00;
          for (int i = 0; i < 8; i++) byte_v[i] = m_bits[i];
          ones        = $countones(byte_v) + int'(m_bits[8]);
          exp_pe_even = (ones % 2) != 0;
          exp_pe_odd  = (ones % 2) != 1;
          exp_fe      = !m_bits[9];
          exp_valid   = 1'b1;
          exp_data    = byte_v;
          m_active    = 1'b0;
        end
      end
    end
    exp_busy = m_active;
  endtask

  // One clock: apply inputs on the falling edge, let the DUT take them on the
  // rising edge, compare both receivers on the next falling edge.
  task automatic cycle(input bit e, input bit d, input bit r);
    en  = e;
    din = d;
    rst = r;
    @(posedge clk);
    model_step(e, d, r);
    @(negedge clk);
    check("even_valid",   bus_even.valid,   8'(exp_valid));
    check("even_busy",    bus_even.busy,    8'(exp_busy));
    check("even_data",    bus_even.data,    exp_data);
    check("even_par_err", bus_even.par_err, 8'(exp_pe_even));
    check("even_frm_err", bus_even.frm_err, 8'(exp_fe));
    check("odd_valid",    bus_odd.valid,    8'(exp_valid));
    check("odd_busy",     bus_odd.busy,     8'(exp_busy));
    check("odd_data",     bus_odd.data,     exp_data);
    check("odd_par_err",  bus_odd.par_err,  8'(exp_pe_odd));
    check("odd_frm_err",  bus_odd.frm_err,  8'(exp_fe));
  endtask

  // Send one frame; gap disabled cycles (random din) precede every enabled bit.
  task automatic send_frame(input logic [7:0] b, input bit par, input bit stop, input int gap);
    bit frame_bits[11];
    frame_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame_bits[i + 1] = b[i];
    frame_bits[9]  = par;
    frame_bits[10] = stop;
    for (int i = 0; i < 11; i++) begin
      repeat (gap) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      cycle(1'b1, frame_bits[i], 1'b0);
    end
  endtask

  initial begin
    en  = 1'b0;
    din = 1'b1;
    rst = 1'b1;
    @(negedge clk);

    // Reset state.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("rst_data",  bus_even.data,  8'h00);
    check("rst_valid", bus_even.valid, 8'h00);
    check("rst_busy",  bus_even.busy,  8'h00);
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    check("idle_busy", bus_even.busy, 8'h00);

    // 0xA5 with even parity bit, then with parity bit 1.
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check("a5_valid",   bus_even.valid,   8'h01);
    check("a5_data",    bus_even.data,    8'hA5);
    check("a5_pe_even", bus_even.par_err, 8'h00);
    check("a5_fe",      bus_even.frm_err, 8'h00);
    check("a5_pe_odd",  bus_odd.par_err,  8'h01);
    cycle(1'b1, 1'b1, 1'b0);
    check("a5_valid_pulse", bus_even.valid, 8'h00);
    check("a5_data_hold",   bus_even.data,  8'hA5);
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    check("a5p1_pe_even", bus_even.par_err, 8'h01);
    check("a5p1_pe_odd",  bus_odd.par_err,  8'h00);
    check("a5p1_valid",   bus_odd.valid,    8'h01);

    // Framing error.
    send_frame(8'h00, 1'b0, 1'b0, 0);
    check("fe_data",  bus_even.data,    8'h00);
    check("fe_flag",  bus_even.frm_err, 8'h01);
    check("fe_pe",    bus_even.par_err, 8'h00);
    check("fe_valid", bus_even.valid,   8'h01);

    // Sparse enable: one enabled edge in four.
    cycle(1'b1, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 3);
    check("sparse_data",  bus_even.data,  8'h3C);
    check("sparse_valid", bus_even.valid, 8'h01);

    // Reset after 5 data bits aborts the frame.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'(i & 1), 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    check("abort_busy",  bus_even.busy,  8'h00);
    check("abort_valid", bus_even.valid, 8'h00);
    send_frame(8'h81, 1'b0, 1'b1, 0);
    check("after_abort_data", bus_even.data,    8'h81);
    check("after_abort_pe",   bus_even.par_err, 8'h00);

    // Back-to-back frames.
    cycle(1'b1, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, 0);
    check("b2b_first",  bus_even.data, 8'h55);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    check("b2b_second", bus_even.data,    8'hFF);
    check("b2b_pe",     bus_even.par_err, 8'h00);
    check("b2b_fe",     bus_even.frm_err, 8'h00);

    // Random well-formed-ish frames with idle gaps.
    for (int f = 0; f < 60; f++) begin
      repeat ($urandom_range(0, 2)) cycle(1'b1, 1'b1, 1'b0);
      send_frame(8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) != 0), int'($urandom_range(0, 2)));
    end

    // Unstructured random line activity with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
